// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: opcodes, ALU/mux selects, FSM states.
// Optional bne support is enabled by defining MIPS_MC_CTRL_BNE_EN.
package mips_pkg;

  localparam int OPC_WIDTH = 6;
  localparam int ST_WIDTH  = 4;

  localparam logic [OPC_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_WIDTH-1:0] OP_J     = 6'b000010;
  localparam logic [OPC_WIDTH-1:0] OP_BNE   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [ST_WIDTH-1:0] S_FETCH  = 4'd0;
  localparam logic [ST_WIDTH-1:0] S_DECODE = 4'd1;
  localparam logic [ST_WIDTH-1:0] S_MEMADR = 4'd2;
  localparam logic [ST_WIDTH-1:0] S_MEMRD  = 4'd3;
  localparam logic [ST_WIDTH-1:0] S_MEMWB  = 4'd4;
  localparam logic [ST_WIDTH-1:0] S_MEMWR  = 4'd5;
  localparam logic [ST_WIDTH-1:0] S_EXEC   = 4'd6;
  localparam logic [ST_WIDTH-1:0] S_ALUWB  = 4'd7;
  localparam logic [ST_WIDTH-1:0] S_BRANCH = 4'd8;
  localparam logic [ST_WIDTH-1:0] S_ADDIEX = 4'd9;
  localparam logic [ST_WIDTH-1:0] S_ADDIWB = 4'd10;
  localparam logic [ST_WIDTH-1:0] S_JUMP   = 4'd11;
  localparam logic [ST_WIDTH-1:0] S_BNE    = 4'd12;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  // DECODE dispatch; S_FETCH doubles as the "unsupported opcode" result.
  function automatic logic [ST_WIDTH-1:0] decode_target(input logic [OPC_WIDTH-1:0] op);
    case (op)
      OP_RTYPE:     decode_target = S_EXEC;
      OP_LW, OP_SW: decode_target = S_MEMADR;
      OP_BEQ:       decode_target = S_BRANCH;
      OP_ADDI:      decode_target = S_ADDIEX;
      OP_J:         decode_target = S_JUMP;
`ifdef MIPS_MC_CTRL_BNE_EN
      OP_BNE:       decode_target = S_BNE;
`endif
      default:      decode_target = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM main controller sequencing the shared multi-cycle MIPS datapath.
// Define MIPS_MC_CTRL_BNE_EN to add the bne state and the branch_ne output.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int ST_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
`ifdef MIPS_MC_CTRL_BNE_EN
  output logic             branch_ne,
`endif
  output logic             instr_done,
  output logic             illegal_op,
  output logic [ST_W-1:0]  state_o
);

  logic [ST_W-1:0] state_reg, state_next;
  logic [ST_W-1:0] out_state;
  logic            instr_done_reg, instr_done_next;
  logic            illegal_op_reg, illegal_op_next;
  ctl_t            ctl;
`ifdef MIPS_MC_CTRL_BNE_EN
  logic            branch_ne_c;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_FETCH;
      instr_done_reg <= 1'b0;
      illegal_op_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      instr_done_reg <= instr_done_next;
      illegal_op_reg <= illegal_op_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    instr_done_next = 1'b0;
    illegal_op_next = 1'b0;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        state_next      = decode_target(opcode);
        illegal_op_next = (state_next == S_FETCH);
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB: begin
        state_next      = S_FETCH;
        instr_done_next = 1'b1;
      end
      S_MEMWR: if (mem_ready) begin
        state_next      = S_FETCH;
        instr_done_next = 1'b1;
      end
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
`ifdef MIPS_MC_CTRL_BNE_EN
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_BNE: begin
`else
      S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
`endif
        state_next      = S_FETCH;
        instr_done_next = 1'b1;
      end
      default:  state_next = S_FETCH;
    endcase
  end

  // While rst is high the outputs already look like FETCH, so the datapath
  // sees a clean fetch setup the moment reset is released.
  assign out_state = rst ? S_FETCH : state_reg;

  always_comb begin
    ctl = '0;
`ifdef MIPS_MC_CTRL_BNE_EN
    branch_ne_c = 1'b0;
`endif
    case (out_state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: ctl.alu_src_b = SRCB_IMM_SH;
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
`ifdef MIPS_MC_CTRL_BNE_EN
      S_BNE: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
        branch_ne_c       = 1'b1;
      end
`endif
      S_ADDIWB: ctl.reg_write = 1'b1;
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      default: ctl = '0;
    endcase
    // FETCH's ready-gated enables must not fire in the reset cycle itself.
    if (rst) begin
      ctl.pc_write = 1'b0;
      ctl.ir_write = 1'b0;
    end
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign i_or_d        = ctl.i_or_d;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign mem_to_reg    = ctl.mem_to_reg;
  assign reg_dst       = ctl.reg_dst;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_source     = ctl.pc_source;
`ifdef MIPS_MC_CTRL_BNE_EN
  assign branch_ne     = branch_ne_c;
`endif
  assign instr_done    = instr_done_reg;
  assign illegal_op    = illegal_op_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-instruction cycle plans from an
// instruction-level model are queued, and a monitor compares every cycle.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state_o;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } obs_t;

  typedef struct {
    obs_t       c;
    logic [3:0] st;
    string      tag;
  } exp_t;

  // Step numbers as listed for each phase of the instruction flow.
  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5, EX = 6, AWB = 7,
                 BR = 8, AE = 9, AIW = 10, JP = 11;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  bit   stim_done = 0;
  bit   pend_done = 0;
  bit   pend_ill = 0;

  function automatic obs_t phase_ctl(int st, logic mr);
    obs_t c = '0;
    case (st)
      F:   begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      D:   c.alu_src_b = 2'b11;
      MA:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      MR:  begin c.mem_read = 1; c.i_or_d = 1; end
      MWB: begin c.reg_write = 1; c.mem_to_reg = 1; end
      MW:  begin c.mem_write = 1; c.i_or_d = 1; end
      EX:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      AWB: begin c.reg_write = 1; c.reg_dst = 1; end
      BR:  begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      AE:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      AIW: c.reg_write = 1;
      JP:  begin c.pc_write = 1; c.pc_source = 2'b10; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic step(int st, logic mr, logic [5:0] op, string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    mem_ready = mr;
    opcode = op;
    e.c = phase_ctl(st, mr);
    e.c.instr_done = pend_done;
    e.c.illegal_op = pend_ill;
    pend_done = 0;
    pend_ill = 0;
    e.st = st[3:0];
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic mem_phase(int st, int stalls, logic [5:0] op, string tag);
    for (int i = 0; i < stalls; i++) step(st, 1'b0, op, tag);
    step(st, 1'b1, op, tag);
  endtask

  task automatic reset_cycle(logic [3:0] cur_st, string tag);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    e.c = phase_ctl(F, 1'b1);
    e.c.pc_write = 0;
    e.c.ir_write = 0;
    e.c.instr_done = 0;
    e.c.illegal_op = 0;
    pend_done = 0;
    pend_ill = 0;
    e.st = cur_st;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic run_instr(logic [5:0] op, int fst, int mst);
    int    seq[$];
    string tag;
    int    n;
    tag = $sformatf("op%02h", op);
    case (op)
      6'b100011: seq = '{MA, MR, MWB};
      6'b101011: seq = '{MA, MW};
      6'b000000: seq = '{EX, AWB};
      6'b000100: seq = '{BR};
      6'b001000: seq = '{AE, AIW};
      6'b000010: seq = '{JP};
      default:   seq = '{};
    endcase
    mem_phase(F, fst, op, tag);
    step(D, 1'($urandom_range(0, 1)), op, tag);
    foreach (seq[i]) begin
      if (seq[i] == MR || seq[i] == MW) mem_phase(seq[i], mst, op, tag);
      else step(seq[i], 1'($urandom_range(0, 1)), op, tag);
    end
    if (seq.size() == 0) pend_ill = 1;
    else pend_done = 1;
    n = 2 + fst + seq.size() + ((op == 6'b100011 || op == 6'b101011) ? mst : 0);
    $display("instr op=%06b fetch_stall=%0d mem_stall=%0d cycles=%0d %s",
             op, fst, mst, n, (seq.size() == 0) ? "illegal" : "retire");
  endtask

  task automatic lw_with_reset(int mst);
    string tag = "lw_rst";
    mem_phase(F, 0, 6'b100011, tag);
    step(D, 1'b1, 6'b100011, tag);
    step(MA, 1'b1, 6'b100011, tag);
    for (int i = 0; i < mst; i++) step(MR, 1'b0, 6'b100011, tag);
    reset_cycle(4'd3, tag);
    $display("instr op=100011 reset in MEMRD after %0d stall cycles", mst);
  endtask

  // Monitor: one queued expectation per cycle, sampled mid low phase.
  initial begin
    obs_t a;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cyc++;
        a = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, instr_done, illegal_op};
        compared++;
        if (a !== e.c) begin
          mismatched++;
          $display("FAIL ctl %s cyc=%0d got=%05h exp=%05h", e.tag, cyc, a, e.c);
        end
        compared++;
        if (state_o !== e.st) begin
          mismatched++;
          $display("FAIL state %s cyc=%0d got=%0d exp=%0d", e.tag, cyc, state_o, e.st);
        end
      end else if (stim_done) begin
        break;
      end
    end
  end

  initial begin
    logic [5:0] op_tab [8];
    logic [5:0] op;
    op_tab = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
               6'b001000, 6'b000010, 6'b000101, 6'b111111};
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = 6'b0;
    reset_cycle(4'd0, "reset");
    reset_cycle(4'd0, "reset");

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 3);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b100011, 2, 2);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000101, 1, 0);
    lw_with_reset(1);
    run_instr(6'b000000, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        lw_with_reset($urandom_range(0, 2));
      end else begin
        op = op_tab[$urandom_range(0, 7)];
        if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
        run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end
    end
    run_instr(6'b000010, 0, 0);

    stim_done = 1;
    repeat (4) @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
